// File: rtl/vip_test_pattern_source.sv
// rtl/vip_test_pattern_source.sv - Avalon-ST Video test pattern source (control packet + video packet per frame)
// Optional interlaced field generation: define VIP_TPG_INTERLACED_EN.
module vip_test_pattern_source #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enable,
  input  logic [1:0]                                  pattern_sel,
  input  logic [15:0]                                 width_in,
  input  logic [15:0]                                 height_in,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                 frame_count,
  output logic                                        busy
);

  localparam int BPS = BITS_PER_SYMBOL;
  localparam int SPB = SYMBOLS_PER_BEAT;
  localparam int DW  = BPS * SPB;
  localparam int NCTRL = (9 + SPB - 1) / SPB;
  localparam logic [3:0] LAST_CTRL = 4'(NCTRL - 1);

  typedef enum logic [2:0] {IDLE, CTRL_HDR, CTRL_DATA, VID_HDR, VID_DATA} state_t;

  state_t          state_q, state_d;
  logic [15:0]     w_q, w_d, h_q, h_d;
  logic [1:0]      pat_q, pat_d;
  logic [15:0]     x_q, x_d, y_q, y_d;
  logic [15:0]     nx, ny;
  logic [3:0]      cidx_q, cidx_d;
  logic            valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DW-1:0]   data_q, data_d;
  logic [15:0]     fc_q, fc_d;
  logic [15:0]     lines;
  logic [3:0]      il_nibble;

`ifdef VIP_TPG_INTERLACED_EN
  logic            field_q, field_d;
  // A one-line frame still produces a one-line field so the packet can terminate.
  assign lines     = (h_q[15:1] == 15'd0) ? 16'd1 : {1'b0, h_q[15:1]};
  assign il_nibble = field_q ? 4'b1100 : 4'b1000;
`else
  assign lines     = h_q;
  assign il_nibble = 4'b0000;
`endif

  // Nibble n goes to bits [3:0] of symbol n%SPB in control beat n/SPB.
  function automatic logic [DW-1:0] ctrl_beat(input logic [3:0] bidx, input logic [15:0] w,
                                               input logic [15:0] h, input logic [3:0] il);
    logic [35:0]   nib;
    logic [DW-1:0] r;
    int            n;
    nib = {il, h[3:0], h[7:4], h[11:8], h[15:12], w[3:0], w[7:4], w[11:8], w[15:12]};
    r = '0;
    for (int s = 0; s < SPB; s++) begin
      n = int'(bidx) * SPB + s;
      if (n < 9) r[s*BPS +: 4] = nib[n*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] pixel_beat(input logic [15:0] px, input logic [15:0] py,
                                                input logic [15:0] fc, input logic [1:0] pat);
    logic [DW-1:0] r;
    r = '0;
    case (pat)
      2'd0: begin
        for (int s = 0; s < SPB; s++) begin
          case (s)
            0:       r[s*BPS +: 8] = px[7:0];
            1:       r[s*BPS +: 8] = py[7:0];
            2:       r[s*BPS +: 8] = fc[7:0];
            default: r[s*BPS +: 8] = 8'h00;
          endcase
        end
      end
      2'd1:    r = (px[3] ^ py[3]) ? '1 : '0;
      2'd2:    r = '0;
      default: r = '1;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      pat_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cidx_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      fc_q    <= '0;
`ifdef VIP_TPG_INTERLACED_EN
      field_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      pat_q   <= pat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cidx_q  <= cidx_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
      fc_q    <= fc_d;
`ifdef VIP_TPG_INTERLACED_EN
      field_q <= field_d;
`endif
    end
  end

  // Every non-IDLE state presents a valid beat; the next beat is loaded only on a transfer.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    pat_d   = pat_q;
    x_d     = x_q;
    y_d     = y_q;
    cidx_d  = cidx_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;
    fc_d    = fc_q;
    nx      = (x_q == w_q - 16'd1) ? 16'd0 : x_q + 16'd1;
    ny      = (x_q == w_q - 16'd1) ? y_q + 16'd1 : y_q;
`ifdef VIP_TPG_INTERLACED_EN
    field_d = field_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable && width_in != 16'd0 && height_in != 16'd0) begin
          w_d         = width_in;
          h_d         = height_in;
          pat_d       = pattern_sel;
          state_d     = CTRL_HDR;
          valid_d     = 1'b1;
          sop_d       = 1'b1;
          eop_d       = 1'b0;
          data_d      = '0;
          data_d[3:0] = 4'hF;
        end
      end
      CTRL_HDR: begin
        if (dout_ready) begin
          state_d = CTRL_DATA;
          cidx_d  = 4'd0;
          sop_d   = 1'b0;
          eop_d   = (LAST_CTRL == 4'd0);
          data_d  = ctrl_beat(4'd0, w_q, h_q, il_nibble);
        end
      end
      CTRL_DATA: begin
        if (dout_ready) begin
          if (cidx_q == LAST_CTRL) begin
            state_d = VID_HDR;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            data_d  = '0;
          end else begin
            cidx_d = cidx_q + 4'd1;
            eop_d  = (cidx_q + 4'd1 == LAST_CTRL);
            data_d = ctrl_beat(cidx_q + 4'd1, w_q, h_q, il_nibble);
          end
        end
      end
      VID_HDR: begin
        if (dout_ready) begin
          state_d = VID_DATA;
          x_d     = 16'd0;
          y_d     = 16'd0;
          sop_d   = 1'b0;
          eop_d   = (w_q == 16'd1) && (lines == 16'd1);
          data_d  = pixel_beat(16'd0, 16'd0, fc_q, pat_q);
        end
      end
      VID_DATA: begin
        if (dout_ready) begin
          if (eop_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            eop_d   = 1'b0;
            data_d  = '0;
`ifdef VIP_TPG_INTERLACED_EN
            if (field_q) fc_d = fc_q + 16'd1;
            field_d = ~field_q;
`else
            fc_d = fc_q + 16'd1;
`endif
          end else begin
            x_d    = nx;
            y_d    = ny;
            eop_d  = (nx == w_q - 16'd1) && (ny == lines - 16'd1);
            data_d = pixel_beat(nx, ny, fc_q, pat_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout_valid  = valid_q;
  assign dout_sop    = sop_q;
  assign dout_eop    = eop_q;
  assign dout_data   = data_q;
  assign frame_count = fc_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_vip_test_pattern_source.sv
// tb/tb_vip_test_pattern_source.sv - scoreboard bench for vip_test_pattern_source (progressive build)
module tb_vip_test_pattern_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] width_in = 16'd0;
  logic [15:0] height_in = 16'd0;
  logic        dout_ready = 1'b1;
  logic        dout_valid, dout_sop, dout_eop;
  logic [23:0] dout_data;
  logic [15:0] frame_count;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [25:0] exp_q[$];
  logic [25:0] held_beat;
  logic        stall_pend = 1'b0;
  logic        rand_ready = 1'b0;
  logic [23:0] cap[0:299];
  int          cap_n = 0;
  int          vcyc;

  vip_test_pattern_source #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .width_in(width_in), .height_in(height_in), .dout_ready(dout_ready),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_data(dout_data), .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    else            dout_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops expected beats on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        tests++;
        if (!dout_valid || {dout_sop, dout_eop, dout_data} !== held_beat) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b beat=0x%0h expected v=1 beat=0x%0h",
                   dout_valid, {dout_sop, dout_eop, dout_data}, held_beat);
        end
      end
      if (dout_valid && dout_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got 0x%0h expected none", {dout_sop, dout_eop, dout_data});
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          if ({dout_sop, dout_eop, dout_data} !== e) begin
            fails++;
            $display("FAIL beat: got sop/eop/data 0x%0h expected 0x%0h", {dout_sop, dout_eop, dout_data}, e);
          end
        end
        if (cap_n < 300) cap[cap_n] = dout_data;
        cap_n++;
      end
      stall_pend = dout_valid && !dout_ready;
      held_beat  = {dout_sop, dout_eop, dout_data};
    end
  end

  task automatic push(input logic sop, input logic eop, input logic [23:0] d);
    exp_q.push_back({sop, eop, d});
  endtask

  task automatic push_frame(input int w, input int h, input logic [1:0] pat, input logic [7:0] fc,
                            input logic [23:0] c0, input logic [23:0] c1, input logic [23:0] c2);
    logic [15:0] xx, yy;
    logic [23:0] px;
    push(1, 0, 24'h00000F);
    push(0, 0, c0);
    push(0, 0, c1);
    push(0, 1, c2);
    push(1, 0, 24'h000000);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        xx = 16'(x);
        yy = 16'(y);
        if (pat == 2'd0) px = {fc, yy[7:0], xx[7:0]};
        else             px = (xx[3] ^ yy[3]) ? 24'hFFFFFF : 24'h000000;
        push(0, (x == w - 1) && (y == h - 1), px);
      end
  endtask

  task automatic start_frame(input logic [15:0] w, input logic [15:0] h, input logic [1:0] pat);
    @(posedge clk); #1;
    width_in = w; height_in = h; pattern_sel = pat; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_frame(input string name, output int nvalid);
    int n;
    nvalid = 0;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      if (dout_valid) nvalid++;
      n++;
      @(negedge clk);
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
  endtask

  initial begin
    #12;
    check("reset_valid", 32'(dout_valid), 0);
    check("reset_sop", 32'(dout_sop), 0);
    check("reset_eop", 32'(dout_eop), 0);
    check("reset_data", 32'(dout_data), 0);
    check("reset_fc", 32'(frame_count), 0);
    check("reset_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Frame 1: hand-computed beats, ready held high.
    push(1, 0, 24'h00000F); push(0, 0, 24'h000000); push(0, 0, 24'h000004); push(0, 1, 24'h000200);
    push(1, 0, 24'h000000);
    push(0, 0, 24'h000000); push(0, 0, 24'h000001); push(0, 0, 24'h000002); push(0, 0, 24'h000003);
    push(0, 0, 24'h000100); push(0, 0, 24'h000101); push(0, 0, 24'h000102); push(0, 1, 24'h000103);
    start_frame(16'd4, 16'd2, 2'd0);
    wait_frame("frame1", vcyc);
    check("frame1_valid_cycles", 32'(vcyc), 13);
    check("frame1_fc", 32'(frame_count), 1);
    check("frame1_drained", 32'(exp_q.size()), 0);

    // Frame 2: random backpressure; frame_count=1 lands in symbol 2.
    rand_ready = 1'b1;
    push(1, 0, 24'h00000F); push(0, 0, 24'h000000); push(0, 0, 24'h000004); push(0, 1, 24'h000200);
    push(1, 0, 24'h000000);
    push(0, 0, 24'h010000); push(0, 0, 24'h010001); push(0, 0, 24'h010002); push(0, 0, 24'h010003);
    push(0, 0, 24'h010100); push(0, 0, 24'h010101); push(0, 0, 24'h010102); push(0, 1, 24'h010103);
    start_frame(16'd4, 16'd2, 2'd0);
    wait_frame("frame2", vcyc);
    rand_ready = 1'b0;
    check("frame2_fc", 32'(frame_count), 2);
    check("frame2_drained", 32'(exp_q.size()), 0);

    // Frame 3: enable held, then dropped while pixel (2,0) is presented.
    push_frame(4, 2, 2'd0, 8'd2, 24'h000000, 24'h000004, 24'h000200);
    @(posedge clk); #1;
    width_in = 16'd4; height_in = 16'd2; pattern_sel = 2'd0; enable = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(dout_valid && !dout_sop && dout_data == 24'h020002) && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("frame3_found_x2", 32'(n < 100), 1);
    end
    enable = 1'b0;
    wait_frame("frame3", vcyc);
    check("frame3_fc", 32'(frame_count), 3);
    check("frame3_drained", 32'(exp_q.size()), 0);
    begin
      int bad;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (dout_valid || dout_sop || busy) bad++;
      end
      check("no_restart_when_disabled", 32'(bad), 0);
    end

    // Zero width keeps the block idle.
    @(posedge clk); #1;
    width_in = 16'd0; height_in = 16'd5; enable = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (dout_valid || busy) bad++;
      end
      check("zero_width_idle", 32'(bad), 0);
    end
    enable = 1'b0;

    // Checkerboard 16x16: W=H=0x0010 gives control beats 0x010000, 0x000000, 0x000001.
    push_frame(16, 16, 2'd1, 8'd3, 24'h010000, 24'h000000, 24'h000001);
    cap_n = 0;
    start_frame(16'd16, 16'd16, 2'd1);
    wait_frame("checker", vcyc);
    check("checker_beats", 32'(cap_n), 261);
    check("checker_px_8_0", 32'(cap[5 + 0 * 16 + 8]), 32'hFFFFFF);
    check("checker_px_8_8", 32'(cap[5 + 8 * 16 + 8]), 32'h000000);
    check("checker_px_0_8", 32'(cap[5 + 8 * 16 + 0]), 32'hFFFFFF);
    check("checker_fc", 32'(frame_count), 4);

    // Reset in the middle of the video packet.
    push_frame(4, 2, 2'd0, 8'd4, 24'h000000, 24'h000004, 24'h000200);
    @(posedge clk); #1;
    width_in = 16'd4; height_in = 16'd2; pattern_sel = 2'd0; enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(dout_valid && !dout_sop && dout_data == 24'h040001) && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("rst_found_px1", 32'(n < 100), 1);
    end
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(dout_valid), 0);
    check("rst_async_fc", 32'(frame_count), 0);
    check("rst_async_busy", 32'(busy), 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    push_frame(4, 2, 2'd0, 8'd0, 24'h000000, 24'h000004, 24'h000200);
    start_frame(16'd4, 16'd2, 2'd0);
    wait_frame("post_rst", vcyc);
    check("post_rst_valid_cycles", 32'(vcyc), 13);
    check("post_rst_fc", 32'(frame_count), 1);
    check("post_rst_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
